// File: rtl/zero_scan_ctrl.sv
// zero_scan_ctrl
//   Frame-level controller around a serial Mealy 1->0 transition detector.
//   A WIDTH-bit word is taken over a valid/ready handshake and shifted out
//   LSB-first through a 4-state detector. Detections are counted, the first
//   detection index is captured, and the result is offered over a second
//   valid/ready handshake.
//
//   Ports:
//     clk, reset             rising-edge clock, synchronous active-high reset
//     in_valid/in_ready      frame word handshake (accepted only in IDLE)
//     in_data[WIDTH]         frame word, bit 0 serialised first
//     ser_x                  bit presented to the detector (SHIFT only)
//     y_pulse                detector Mealy output for the current bit
//     busy                   high while a frame is shifting or awaiting pickup
//     out_valid/out_ready    result handshake
//     det_count[CW]          saturating detection count
//     det_first[IW]          index of first detection, all-ones if none
//     det_any                at least one detection seen
//
//   Optional build macro ZSCAN_CHAIN_EN: when defined the detector state is
//   carried across frames instead of being cleared at frame accept.
module zero_scan_ctrl #(
  parameter int WIDTH = 8,
  parameter int CW    = 4,
  parameter int IW    = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             ser_x,
  output logic             y_pulse,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CW-1:0]    det_count,
  output logic [IW-1:0]    det_first,
  output logic             det_any
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] sreg;
  logic [IW-1:0]    bitcnt;
  logic [1:0]       det_st;
  logic [CW-1:0]    cnt_r;
  logic [IW-1:0]    first_r;
  logic             any_r;
  logic             last_bit;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  // Detector state (A,B): any 0 returns to 00; a run of 1s walks 00->01->11->10
  // and parks in 10. Every non-zero state means "previous bit was 1".
  function automatic logic [1:0] det_next(input logic [1:0] st, input logic x);
    logic [1:0] nx;
    nx = 2'b00;
    if (x) begin
      unique case (st)
        2'b00:   nx = 2'b01;
        2'b01:   nx = 2'b11;
        2'b11:   nx = 2'b10;
        default: nx = 2'b10;
      endcase
    end
    return nx;
  endfunction

  assign last_bit  = (bitcnt == IW'(WIDTH - 1));
  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign out_valid = (state == DONE);
  assign ser_x     = (state == SHIFT) & sreg[0];
  assign y_pulse   = (state == SHIFT) & (|det_st) & ~sreg[0];
  assign det_count = cnt_r;
  assign det_first = first_r;
  assign det_any   = any_r;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (in_valid)  state_nx = SHIFT;
      SHIFT:   if (last_bit)  state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      sreg    <= '0;
      bitcnt  <= '0;
      det_st  <= 2'b00;
      cnt_r   <= '0;
      first_r <= '1;
      any_r   <= 1'b0;
    end else begin
      state <= state_nx;
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            sreg    <= in_data;
            bitcnt  <= '0;
            cnt_r   <= '0;
            first_r <= '1;
            any_r   <= 1'b0;
`ifdef ZSCAN_CHAIN_EN
            // detector state deliberately kept from the previous frame
`else
            det_st  <= 2'b00;
`endif
          end
        end
        SHIFT: begin
          det_st <= det_next(det_st, sreg[0]);
          sreg   <= sreg >> 1;
          bitcnt <= bitcnt + 1'b1;
          if (y_pulse) begin
            cnt_r <= sat_inc(cnt_r);
            any_r <= 1'b1;
            if (!any_r) first_r <= bitcnt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_zero_scan_ctrl.sv
module tb_zero_scan_ctrl;
  localparam int W  = 8;
  localparam int CW = 4;
  localparam int IW = 5;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_data = '0;
  logic          ser_x;
  logic          y_pulse;
  logic          busy;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [CW-1:0] det_count;
  logic [IW-1:0] det_first;
  logic          det_any;

  int passed = 0;
  int total  = 0;

  zero_scan_ctrl #(.WIDTH(W), .CW(CW), .IW(IW)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .ser_x(ser_x), .y_pulse(y_pulse), .busy(busy),
    .out_valid(out_valid), .out_ready(out_ready),
    .det_count(det_count), .det_first(det_first), .det_any(det_any)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // phase: -1 idle, 0..W-1 presenting that bit index, W waiting for pickup.
  // A detection is simply "this bit is 0 and the previously processed bit was 1".
  int            m_phase = -1;
  logic [W-1:0]  m_word  = '0;
  logic          m_prev  = 1'b0;
  logic [CW-1:0] m_cnt   = '0;
  logic [IW-1:0] m_first = '1;
  logic          m_any   = 1'b0;
  logic          m_live  = 1'b0;
  logic          m_y;
  logic          m_bit;

  always_comb begin
    m_bit = 1'b0;
    m_y   = 1'b0;
    if (m_phase >= 0 && m_phase < W) begin
      m_bit = m_word[m_phase];
      m_y   = m_prev && !m_bit;
    end
  end

  always @(posedge clk) begin
    if (reset) begin
      m_phase <= -1; m_cnt <= '0; m_first <= '1; m_any <= 1'b0;
      m_prev <= 1'b0; m_live <= 1'b1;
    end else if (m_phase == -1) begin
      if (in_valid) begin
        m_word <= in_data; m_phase <= 0; m_cnt <= '0; m_first <= '1; m_any <= 1'b0;
`ifndef ZSCAN_CHAIN_EN
        m_prev <= 1'b0;
`endif
      end
    end else if (m_phase < W) begin
      if (m_y) begin
        m_cnt <= (m_cnt == '1) ? m_cnt : m_cnt + 1'b1;
        m_any <= 1'b1;
        if (!m_any) m_first <= IW'(m_phase);
      end
      m_prev  <= m_bit;
      m_phase <= m_phase + 1;
    end else if (out_ready) begin
      m_phase <= -1;
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      chk("in_ready",  32'(in_ready),  32'(m_phase == -1));
      chk("busy",      32'(busy),      32'(m_phase >= 0));
      chk("out_valid", 32'(out_valid), 32'(m_phase == W));
      chk("y_pulse",   32'(y_pulse),   32'(m_y));
      chk("det_count", 32'(det_count), 32'(m_cnt));
      chk("det_first", 32'(det_first), 32'(m_first));
      chk("det_any",   32'(det_any),   32'(m_any));
      if (m_phase >= 0 && m_phase < W) chk("ser_x", 32'(ser_x), 32'(m_bit));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Offers a word, waits for acceptance, then waits for out_valid. Returns
  // cycles from accept to out_valid and the y_pulse mask by bit index.
  task automatic run_frame(input logic [W-1:0] w, output int lat, output logic [31:0] ym);
    int n;
    bit ok;
    ym = '0;
    lat = -1;
    in_valid = 1'b1;
    in_data  = w;
    ok = 0;
    for (n = 0; n < 50; n++) begin
      if (in_ready) begin ok = 1; break; end
      tick();
    end
    if (!ok) chk("accept_timeout", 32'd0, 32'd1);
    tick();
    in_valid = 1'b0;
    for (n = 0; n < 50; n++) begin
      if (out_valid) begin lat = n; break; end
      ym[n] = y_pulse;
      tick();
    end
    if (lat < 0) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    int lat;
    logic [31:0] ym;
    tick(); tick();
    reset = 1'b0;
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_ser_x",     32'(ser_x),     32'd0);
    chk("rst_count",     32'(det_count), 32'd0);
    chk("rst_first",     32'(det_first), 32'h1F);
    chk("rst_any",       32'(det_any),   32'd0);

    // 0x55: detections at 1,3,5,7
    run_frame(8'h55, lat, ym);
    chk("55_latency", 32'(lat), 32'd8);
    chk("55_ymask",   ym, 32'h000000AA);
    chk("55_count",   32'(det_count), 32'd4);
    chk("55_first",   32'(det_first), 32'd1);
    chk("55_any",     32'(det_any),   32'd1);

    // backpressure with a new word already offered
    in_valid = 1'b1;
    in_data  = 8'h0E;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_ready", 32'(in_ready),  32'd0);
      chk("hold_count", 32'(det_count), 32'd4);
      chk("hold_first", 32'(det_first), 32'd1);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("hold_idle_ready", 32'(in_ready),  32'd1);
    chk("hold_idle_valid", 32'(out_valid), 32'd0);
    chk("hold_idle_count", 32'(det_count), 32'd4);
    run_frame(8'h0E, lat, ym);
    chk("0E_ymask", ym, 32'h00000010);
    chk("0E_count", 32'(det_count), 32'd1);
    chk("0E_first", 32'(det_first), 32'd4);
    release_result();

    run_frame(8'h00, lat, ym);
    chk("00_count", 32'(det_count), 32'd0);
    chk("00_any",   32'(det_any),   32'd0);
    chk("00_first", 32'(det_first), 32'h1F);
    release_result();
    run_frame(8'hFF, lat, ym);
    chk("FF_count", 32'(det_count), 32'd0);
    chk("FF_any",   32'(det_any),   32'd0);
    chk("FF_first", 32'(det_first), 32'h1F);
    release_result();

    // reset in the 3rd SHIFT cycle aborts the frame
    in_valid = 1'b1;
    in_data  = 8'h55;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    chk("abort_busy_before", 32'(busy), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_in_ready",  32'(in_ready),  32'd1);
    chk("abort_busy",      32'(busy),      32'd0);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_count",     32'(det_count), 32'd0);
    chk("abort_first",     32'(det_first), 32'h1F);
    chk("abort_any",       32'(det_any),   32'd0);
    for (int i = 0; i < 12; i++) begin
      chk("abort_no_valid", 32'(out_valid), 32'd0);
      tick();
    end
    run_frame(8'h55, lat, ym);
    chk("post_abort_count", 32'(det_count), 32'd4);
    release_result();

    // chaining across frames
    run_frame(8'h80, lat, ym);
    chk("80_count", 32'(det_count), 32'd0);
    release_result();
    run_frame(8'h00, lat, ym);
`ifdef ZSCAN_CHAIN_EN
    chk("chain_count", 32'(det_count), 32'd1);
    chk("chain_first", 32'(det_first), 32'd0);
`else
    chk("chain_count", 32'(det_count), 32'd0);
    chk("chain_first", 32'(det_first), 32'h1F);
`endif
    release_result();

    // random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      in_valid  = ($urandom_range(0, 2) != 0);
      in_data   = W'($urandom);
      out_ready = ($urandom_range(0, 3) == 0);
      reset     = ($urandom_range(0, 199) == 0);
      tick();
    end
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    tick(); tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/zero_scan_ctrl.md
Name: zero_scan_ctrl

Overview:
- Frame-level controller for the serial Mealy zero-detector function (output asserted when a 0 bit follows one or more 1 bits, i.e. a 1→0 transition).
- Accepts a parallel word over a valid/ready handshake and serialises it LSB-first through an internal 4-state Mealy detector.
- Counts detections and records the first detection position.
- Returns the result over a second valid/ready handshake.
- Sits between a word-oriented producer and the serial detection logic. It sequences the detector so upstream logic never drives bit-level timing.

Parameters:
- WIDTH, 8, bits per frame; legal range 2..32.
- CW, 4, width of detection count; saturates at all-ones if too narrow.
- IW, 5, width of first-detection index; must satisfy 2^IW > WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  frame word offered.
- in_ready  output  1  controller can accept a frame.
- in_data  input  WIDTH  frame word; bit 0 is serialised first.
- ser_x  output  1  bit currently presented to the detector.
- y_pulse  output  1  Mealy detector output for the current bit (SHIFT only).
- busy  output  1  high in SHIFT and DONE.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts the result.
- det_count  output  CW  number of detections in the frame.
- det_first  output  IW  bit index of first detection; all-ones if none.
- det_any  output  1  at least one detection in the frame.

Behaviour:
- Reset is synchronous and active-high. On reset every register clears and the FSM enters IDLE.
- Output values in reset: in_ready=1 (IDLE), ser_x=0, y_pulse=0, busy=0, out_valid=0, det_count=0, det_first=all-ones, det_any=0.
- FSM states are IDLE, SHIFT and DONE.
- IDLE:
  - in_ready=1.
  - When in_valid is high on an edge: load the shift register with in_data, clear the bit counter, det_count, det_any and the detector state (A=B=0), set det_first to all-ones, then go to SHIFT.
- SHIFT:
  - in_ready=0.
  - ser_x = shift register bit 0.
  - Detector state encoding (A,B) with next-state rules:
    - x=1: 00→01, 01→11, 11→10, 10→10.
    - x=0: any state→00.
  - y_pulse = (A|B) & ~ser_x, combinational in the same cycle.
  - On each edge, advance the detector state, shift the register right by one, and increment the bit counter.
  - When y_pulse=1: increment det_count (saturating) and set det_any. If det_any was 0, capture the bit counter into det_first.
  - After the edge that processes bit WIDTH-1, go to DONE.
  - The detector state resets at every frame start, so bit 0 can never produce a detection.
- DONE:
  - out_valid=1 and the result outputs are held stable.
  - When out_ready is high on an edge, go to IDLE. out_valid falls in the next cycle.
- Latency: the frame is accepted at edge 0. SHIFT occupies the cycles after edges 0..WIDTH-1. out_valid is high in the cycle after edge WIDTH. Minimum frame period is WIDTH+2 cycles.
- Frames never overlap. in_data and in_valid are ignored outside IDLE.
- Backpressure: if out_ready stays low, DONE persists indefinitely and all outputs stay constant.
- in_valid and out_ready may both be high in DONE. The frame completes in DONE, but the new word is accepted only in the following IDLE cycle.
- Result outputs keep their last values in IDLE until the next frame is accepted.
- Reset asserted mid-SHIFT or mid-DONE aborts the frame: the result is discarded and no out_valid is produced.

Optional Feature:
- Macro: ZSCAN_CHAIN_EN.
- Defined: the detector state is not cleared at frame accept. It carries over from the last bit of the previous frame, so a frame whose bit 0 is 0 after a previous frame ending in 1 detects at index 0. Reset still clears the state.
- Undefined: the detector state clears at every accept, as described in Behaviour.

Test Plan:
- Reset, then in_data=8'h55 (bits 1,0,1,0,1,0,1,0) → y_pulse at bit indices 1,3,5,7; det_count=4, det_first=1, det_any=1; out_valid in the 9th cycle after accept.
- in_data=8'h00 and then 8'hFF → det_count=0, det_any=0, det_first=5'h1F for both frames.
- in_data=8'h0E (bits 0,1,1,1,0,0,0,0) → single y_pulse at index 4; det_count=1, det_first=4.
- Hold out_ready=0 for 5 cycles in DONE with in_valid=1 → out_valid and the results stay stable, in_ready=0. Raise out_ready → IDLE, then the next word is accepted.
- Assert reset during the 3rd SHIFT cycle → next cycle is IDLE, all outputs at reset values, no out_valid. A subsequent 8'h55 frame gives det_count=4.
- Frame 8'h80 then frame 8'h00:
  - With ZSCAN_CHAIN_EN, the second frame gives det_count=1, det_first=0.
  - Without it, the second frame gives det_count=0.
